rgbw_sout: RTL and testbench

- Downstream stage of rgb_sbit2wrd. Consumes its 32-bit Red/Green/Blue/Status words and converts each RGB triple to RGBW.
- Re-serializes the result as a 32-bit SK6812-RGBW-style NRZ stream on a single output pin, with bit timing counted in 96 MHz clocks.
- Holds one pending word while the current word is shifting out, so the upstream receiver can keep running.

---
 rtl/rgbw_sout.sv | 170 +++++++++++++++++
 tb/tb_rgbw_sout.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbw_sout.sv
// SK6812-RGBW style NRZ serializer fed by rgb_sbit2wrd words, with one-deep holding register.
// Define RGBW_WHITE_EXTRACT_EN to derive W = min(R,G,B) and subtract it; otherwise W = 0.
module rgbw_sout #(
    parameter int T0H_CLKS  = 29,
    parameter int T1H_CLKS  = 58,
    parameter int TBIT_CLKS = 120,
    parameter int TRST_CLKS = 7680
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_word,
    input  logic        in_strobe,
    output logic        sout,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        LATCH
    } state_t;

    localparam logic [15:0] T0H       = 16'(T0H_CLKS);
    localparam logic [15:0] T1H       = 16'(T1H_CLKS);
    localparam logic [15:0] TBIT_LAST = 16'(TBIT_CLKS - 1);
    localparam logic [15:0] TRST_LAST = 16'(TRST_CLKS - 1);

    state_t      state;
    state_t      state_nxt;
    logic        strobe_d;
    logic        hold_valid;
    logic [23:0] hold_rgb;
    logic        hold_rst;
    logic [31:0] shift_reg;
    logic [4:0]  bit_cnt;
    logic [15:0] clk_cnt;
    logic        sout_nxt;
    logic        capture;
    logic        drain;
    logic        bit_end;
    logic [15:0] thx;
    logic        unused_bits;

    logic [7:0] r_in;
    logic [7:0] g_in;
    logic [7:0] b_in;
    logic [7:0] r_out;
    logic [7:0] g_out;
    logic [7:0] b_out;
    logic [7:0] w_out;

    assign unused_bits = ^in_word[29:24];

    assign capture = in_strobe & ~strobe_d & in_word[31];
    assign drain   = (state == IDLE) & hold_valid;
    assign bit_end = (clk_cnt == TBIT_LAST);
    assign thx     = shift_reg[31] ? T1H : T0H;
    assign busy    = (state != IDLE) | hold_valid;

    // Incoming channel bytes arrive MSB at the lowest index, so reverse them here.
    always_comb begin
        r_in = '0;
        g_in = '0;
        b_in = '0;
        for (int i = 0; i < 8; i++) begin
            g_in[i] = hold_rgb[7 - i];
            r_in[i] = hold_rgb[15 - i];
            b_in[i] = hold_rgb[23 - i];
        end
    end

`ifdef RGBW_WHITE_EXTRACT_EN
    logic [7:0] min_rg;
    assign min_rg = (r_in < g_in) ? r_in : g_in;
    assign w_out  = (min_rg < b_in) ? min_rg : b_in;
    assign r_out  = r_in - w_out;
    assign g_out  = g_in - w_out;
    assign b_out  = b_in - w_out;
`else
    assign w_out = '0;
    assign r_out = r_in;
    assign g_out = g_in;
    assign b_out = b_in;
`endif

    always_comb begin
        state_nxt = state;
        sout_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_nxt = hold_rst ? LATCH : SEND;
                end
            end
            SEND: begin
                sout_nxt = (clk_cnt < thx);
                if (bit_end && (bit_cnt == 5'd31)) begin
                    state_nxt = IDLE;
                end
            end
            LATCH: begin
                if (clk_cnt == TRST_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A capture in the cycle the holding register drains is accepted, not dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            strobe_d   <= 1'b0;
            hold_valid <= 1'b0;
            hold_rgb   <= '0;
            hold_rst   <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            clk_cnt    <= '0;
            sout       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state    <= state_nxt;
            strobe_d <= in_strobe;
            sout     <= sout_nxt;

            if (capture) begin
                if (hold_valid && !drain) begin
                    overflow <= 1'b1;
                end else begin
                    hold_rgb   <= in_word[23:0];
                    hold_rst   <= in_word[30];
                    hold_valid <= 1'b1;
                end
            end else if (drain) begin
                hold_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (hold_valid && !hold_rst) begin
                        shift_reg <= {g_out, r_out, b_out, w_out};
                        bit_cnt   <= '0;
                    end
                end
                SEND: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        shift_reg <= {shift_reg[30:0], 1'b0};
                        bit_cnt   <= bit_cnt + 5'd1;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                LATCH: begin
                    if (clk_cnt == TRST_LAST) begin
                        clk_cnt <= '0;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end
                default: clk_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_rgbw_sout.sv
// Self-checking bench for rgbw_sout: decodes sout into frames and compares them with a word-level model.
// Expectations follow RGBW_WHITE_EXTRACT_EN the same way the design build does.
module tb_rgbw_sout;

    localparam int T0H  = 29;
    localparam int T1H  = 58;
    localparam int TBIT = 120;
    localparam int TRST = 7680;
    localparam int FRAME_BUDGET = 32 * TBIT + 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_word;
    logic        in_strobe;
    logic        sout;
    logic        busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    logic [31:0] frames[$];
    int          gaps[$];

    int          mon_high;
    int          mon_low;
    int          mon_last_h;
    int          mon_bits;
    int          mon_gap;
    logic        mon_prev;
    logic [31:0] mon_frame;

    typedef struct {
        logic [31:0] word;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[4];

    always #5 clk = ~clk;

    rgbw_sout #(
        .T0H_CLKS (T0H),
        .T1H_CLKS (T1H),
        .TBIT_CLKS(TBIT),
        .TRST_CLKS(TRST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_word  (in_word),
        .in_strobe(in_strobe),
        .sout     (sout),
        .busy     (busy),
        .overflow (overflow)
    );

    // Word-level model: unpack bit-reversed channel bytes, optionally pull out the white part.
    function automatic logic [31:0] exp_frame(input logic [31:0] w);
        int r = 0;
        int g = 0;
        int b = 0;
        int wh = 0;
        for (int i = 0; i < 8; i++) begin
            if (w[i])      g += (1 << (7 - i));
            if (w[8 + i])  r += (1 << (7 - i));
            if (w[16 + i]) b += (1 << (7 - i));
        end
`ifdef RGBW_WHITE_EXTRACT_EN
        wh = r;
        if (g < wh) wh = g;
        if (b < wh) wh = b;
`endif
        return {8'(g - wh), 8'(r - wh), 8'(b - wh), 8'(wh)};
    endfunction

    function automatic int last_high(input logic [31:0] f);
        return f[0] ? T1H : T0H;
    endfunction

    // Line decoder: pulse widths become bits, 32 bits become a frame with its preceding low gap.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            mon_prev = 1'b0;
            mon_high = 0;
            mon_low  = 100000;
            mon_bits = 0;
            mon_gap  = 0;
        end else if (sout) begin
            if (!mon_prev) begin
                if (mon_bits > 0) begin
                    checks++;
                    if (mon_low != TBIT - mon_last_h) begin
                        errors++;
                        $display("[TB] FAIL bit_low_time: got %0d clocks, expected %0d", mon_low, TBIT - mon_last_h);
                    end
                end else begin
                    mon_gap = mon_low;
                end
                mon_high = 1;
            end else begin
                mon_high++;
            end
            mon_prev = 1'b1;
        end else begin
            if (mon_prev) begin
                checks++;
                if (mon_high != T0H && mon_high != T1H) begin
                    errors++;
                    $display("[TB] FAIL bit_high_time: got %0d clocks, expected %0d or %0d", mon_high, T0H, T1H);
                end
                mon_last_h = mon_high;
                mon_frame  = {mon_frame[30:0], (mon_high == T1H)};
                mon_bits++;
                if (mon_bits == 32) begin
                    frames.push_back(mon_frame);
                    gaps.push_back(mon_gap);
                    mon_bits = 0;
                end
                mon_low = 1;
            end else begin
                mon_low++;
            end
            mon_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] w);
        in_word   = w;
        in_strobe = 1'b1;
        tick(2);
        in_strobe = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (frames.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        checks++;
        if (frames.size() < n) begin
            errors++;
            $display("[TB] FAIL frame_timeout: got %0d frames, expected %0d", frames.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (busy && c < budget) begin
            tick(1);
            c++;
        end
        checkOutput("busy_drops", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] fa;
        logic [31:0] fb;
        int          c;

`ifdef RGBW_WHITE_EXTRACT_EN
        vecs[0] = '{32'h800C_0804, 32'h1000_2010};
        vecs[1] = '{32'h80FF_FFFF, 32'h0000_00FF};
        vecs[2] = '{32'h8000_8001, 32'h8001_0000};
        vecs[3] = '{32'hBF69_C35A, 32'h0069_3C5A};
`else
        vecs[0] = '{32'h800C_0804, 32'h2010_3000};
        vecs[1] = '{32'h80FF_FFFF, 32'hFFFF_FF00};
        vecs[2] = '{32'h8000_8001, 32'h8001_0000};
        vecs[3] = '{32'hBF69_C35A, 32'h5AC3_9600};
`endif

        rst       = 1'b1;
        in_strobe = 1'b0;
        in_word   = '0;
        tick(3);
        checkOutput("reset_sout", 32'(sout), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick(2);

        // Single words from the table; the first also checks capture-to-output latency.
        for (int i = 0; i < 4; i++) begin
            frames.delete();
            gaps.delete();
            if (i == 0) begin
                in_word   = vecs[i].word;
                in_strobe = 1'b1;
                tick(1);
                checkOutput("latency_p0_sout", 32'(sout), 32'd0);
                checkOutput("latency_p0_busy", 32'(busy), 32'd1);
                tick(1);
                checkOutput("latency_p1_sout", 32'(sout), 32'd0);
                in_strobe = 1'b0;
                tick(1);
                checkOutput("latency_p2_sout", 32'(sout), 32'd1);
            end else begin
                applyStimulus(vecs[i].word);
            end
            wait_frames(1, FRAME_BUDGET);
            if (frames.size() > 0) checkOutput($sformatf("table_frame_%0d", i), frames.pop_front(), vecs[i].exp);
            wait_idle(TBIT + 10);
            tick(150);
            checkOutput($sformatf("table_single_capture_%0d", i), 32'(frames.size()), 32'd0);
        end

        // Invalid word: nothing sent, no overflow.
        frames.delete();
        applyStimulus(32'h00FF_FFFF);
        tick(5);
        checkOutput("invalid_busy", 32'(busy), 32'd0);
        checkOutput("invalid_overflow", 32'(overflow), 32'd0);
        tick(200);
        checkOutput("invalid_no_frame", 32'(frames.size()), 32'd0);

        // Three words back to back: one sends, one held, one dropped.
        frames.delete();
        gaps.delete();
        applyStimulus(vecs[1].word);
        tick(1);
        applyStimulus(vecs[3].word);
        tick(1);
        applyStimulus(vecs[2].word);
        tick(1);
        checkOutput("burst_overflow", 32'(overflow), 32'd1);
        checkOutput("burst_busy", 32'(busy), 32'd1);
        wait_frames(2, 2 * FRAME_BUDGET);
        if (frames.size() >= 2) begin
            fa = exp_frame(vecs[1].word);
            fb = exp_frame(vecs[3].word);
            checkOutput("burst_frame_a", frames[0], fa);
            checkOutput("burst_frame_b", frames[1], fb);
            checkOutput("burst_gap", 32'(gaps[1]), 32'(TBIT - last_high(fa) + 1));
        end
        wait_idle(TBIT + 10);
        tick(300);
        checkOutput("burst_frame_count", 32'(frames.size()), 32'd2);

        // Stream reset queued behind a frame, then a data word during the latch.
        frames.delete();
        gaps.delete();
        applyStimulus(vecs[2].word);
        tick(20);
        applyStimulus(32'hC000_0000);
        checkOutput("latch_pending_busy", 32'(busy), 32'd1);
        wait_frames(1, FRAME_BUDGET);
        tick(200);
        checkOutput("latch_sout_low", 32'(sout), 32'd0);
        checkOutput("latch_busy", 32'(busy), 32'd1);
        applyStimulus(vecs[0].word);
        wait_frames(2, TRST + FRAME_BUDGET);
        if (frames.size() >= 2) begin
            fa = exp_frame(vecs[2].word);
            checkOutput("latch_frame_a", frames[0], fa);
            checkOutput("latch_frame_b", frames[1], exp_frame(vecs[0].word));
            checkOutput("latch_gap", 32'(gaps[1]), 32'(TBIT - last_high(fa) + TRST + 2));
        end
        checkOutput("overflow_sticky", 32'(overflow), 32'd1);
        wait_idle(TBIT + 10);

        // Reset in the middle of a '1' bit, then a clean frame.
        frames.delete();
        gaps.delete();
        applyStimulus(vecs[2].word);
        c = 0;
        while (!sout && c < 10) begin
            tick(1);
            c++;
        end
        checkOutput("midbit_first_high", 32'(sout), 32'd1);
        tick(39);
        rst = 1'b1;
        tick(1);
        checkOutput("midbit_reset_sout", 32'(sout), 32'd0);
        checkOutput("midbit_reset_busy", 32'(busy), 32'd0);
        checkOutput("midbit_reset_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick(2);
        applyStimulus(vecs[3].word);
        wait_frames(1, FRAME_BUDGET);
        if (frames.size() > 0) checkOutput("after_reset_frame", frames.pop_front(), vecs[3].exp);
        wait_idle(TBIT + 10);

        // Random words against the model.
        for (int k = 0; k < 4; k++) begin
            frames.delete();
            w     = $urandom;
            w[30] = 1'b0;
            w[31] = ($urandom_range(0, 3) != 0);
            tick($urandom_range(1, 20));
            applyStimulus(w);
            if (w[31]) begin
                wait_frames(1, FRAME_BUDGET);
                if (frames.size() > 0) checkOutput($sformatf("random_frame_%0d", k), frames.pop_front(), exp_frame(w));
                wait_idle(TBIT + 10);
            end else begin
                tick(50);
                checkOutput($sformatf("random_invalid_%0d", k), 32'(frames.size()), 32'd0);
                checkOutput($sformatf("random_invalid_busy_%0d", k), 32'(busy), 32'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
